// File: rtl/exe_mem_issue.sv
// Memory issue stage: decodes a load/store op, checks alignment, issues it to
// the bus, and keeps an in-order FIFO of in-flight ops so that responses are
// returned to the MEM stage in program order. After a flush, responses still
// owed by the bus for discarded ops are counted and dropped.
module exe_mem_issue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 38
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_allowin,
  input  logic [3:0]          in_op,
  input  logic [31:0]         in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic                flush,
  output logic                req,
  output logic                req_wr,
  output logic [1:0]          req_size,
  output logic [31:0]         req_addr,
  output logic [DATA_W/8-1:0] req_wstrb,
  output logic [DATA_W-1:0]   req_wdata,
  input  logic                addr_ok,
  input  logic                data_ok,
  input  logic [DATA_W-1:0]   rdata,
  output logic                out_valid,
  input  logic                out_allowin,
  output logic [DATA_W-1:0]   out_data,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_ale
);

  localparam int NB     = DATA_W / 8;
  localparam int OFF_W  = $clog2(NB);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DISC_W = 8;

  // Shift the response down to byte 0 and extend from the access width.
  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] raw,
                                                 input logic [OFF_W-1:0]  off,
                                                 input logic [1:0]        size,
                                                 input logic              uns);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] keep;
    logic              sgn;
    int                nbits;
    sh    = raw >> {off, 3'b000};
    nbits = 8 << size;
    if (nbits > DATA_W) nbits = DATA_W;
    for (int b = 0; b < DATA_W; b++) keep[b] = (b < nbits);
    sgn = ~uns & sh[nbits-1];
    return (sh & keep) | (sgn ? ~keep : '0);
  endfunction

  logic              in_store, in_uns;
  logic [1:0]        in_size;
  logic [OFF_W-1:0]  in_off;
  logic              in_ale;
  logic [NB-1:0]     size_mask;
  logic [2:0]        lane_mask;

  // FIFO control state
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DISC_W-1:0] discard_q, discard_d;
  logic [DEPTH-1:0]  done_q, done_d;

  // FIFO payload
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [TAG_W-1:0]  tag_d  [DEPTH];
  logic [1:0]        size_q [DEPTH];
  logic [1:0]        size_d [DEPTH];
  logic [OFF_W-1:0]  off_q  [DEPTH];
  logic [OFF_W-1:0]  off_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  uns_q, uns_d, st_q, st_d, ale_q, ale_d;

  logic              can_push, pop, disc_hit, fill, fill_found;
  logic [PTR_W-1:0]  fill_idx;
  logic [DISC_W-1:0] pending_cnt;

  assign {in_store, in_uns, in_size} = in_op;
  assign in_off = in_addr[OFF_W-1:0];

  // Alignment check and access-size byte mask.
  always_comb begin
    in_ale    = 1'b0;
    size_mask = '1;
    lane_mask = 3'((4'd1 << in_size) - 4'd1);
    case (in_size)
      2'd0: begin in_ale = 1'b0;           size_mask = NB'(1);  end
      2'd1: begin in_ale = in_addr[0];     size_mask = NB'(3);  end
      2'd2: begin in_ale = |in_addr[1:0];  size_mask = NB'(15); end
      default: begin
        in_ale    = (DATA_W == 32) || (|in_addr[2:0]);
        size_mask = '1;
      end
    endcase
  end

  // Replicate the low access-width bytes of store data across every lane.
  always_comb begin
    req_wdata = '0;
    for (int i = 0; i < NB; i++) req_wdata[8*i +: 8] = in_wdata[8*(i & int'(lane_mask)) +: 8];
  end

  assign can_push   = count_q < CNT_W'(DEPTH);
  assign req        = in_valid & ~in_ale & can_push & ~flush & ~reset;
  assign in_allowin = in_valid & can_push & ~flush & ~reset & (in_ale | addr_ok);
  assign req_wr     = in_store;
  assign req_size   = in_size;
  assign req_addr   = in_addr;
  assign req_wstrb  = size_mask << in_off;

  assign out_valid  = (count_q != '0) & done_q[head_q];
  assign out_data   = data_q[head_q];
  assign out_tag    = tag_q[head_q];
  assign out_ale    = ale_q[head_q];

  assign pop        = out_valid & out_allowin;
  assign disc_hit   = data_ok & (discard_q != '0);
  assign fill       = data_ok & ~disc_hit & fill_found;

  // Locate the oldest issued-but-unanswered entry and count all such entries.
  always_comb begin
    fill_found  = 1'b0;
    fill_idx    = head_q;
    pending_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q && !done_q[head_q + PTR_W'(i)]) begin
        if (!fill_found) begin
          fill_found = 1'b1;
          fill_idx   = head_q + PTR_W'(i);
        end
        pending_cnt = pending_cnt + 1'b1;
      end
    end
  end

  // Next-state for pointers, count, discard counter, and entry contents.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    discard_d = discard_q;
    done_d    = done_q;
    tag_d     = tag_q;
    size_d    = size_q;
    off_d     = off_q;
    data_d    = data_q;
    uns_d     = uns_q;
    st_d      = st_q;
    ale_d     = ale_q;

    if (fill) begin
      done_d[fill_idx] = 1'b1;
      data_d[fill_idx] = st_q[fill_idx] ? '0
                       : load_ext(rdata, off_q[fill_idx], size_q[fill_idx], uns_q[fill_idx]);
    end

    if (flush) begin
      // Responses a coincident data_ok already accounted for are not re-counted.
      head_d    = tail_q;
      count_d   = '0;
      discard_d = discard_q - DISC_W'(disc_hit) + pending_cnt - DISC_W'(fill);
    end else begin
      discard_d = discard_q - DISC_W'(disc_hit);
      if (pop) head_d = head_q + PTR_W'(1);
      if (in_allowin) begin
        tail_d         = tail_q + PTR_W'(1);
        tag_d[tail_q]  = in_tag;
        size_d[tail_q] = in_size;
        off_d[tail_q]  = in_off;
        uns_d[tail_q]  = in_uns;
        st_d[tail_q]   = in_store;
        ale_d[tail_q]  = in_ale;
        done_d[tail_q] = in_ale;
        data_d[tail_q] = '0;
      end
      count_d = count_q + CNT_W'(in_allowin) - CNT_W'(pop);
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      discard_q <= '0;
      done_q    <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      discard_q <= discard_d;
      done_q    <= done_d;
    end
  end

  // Payload register; only meaningful while the matching entry is live.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    size_q <= size_d;
    off_q  <= off_d;
    data_q <= data_d;
    uns_q  <= uns_d;
    st_q   <= st_d;
    ale_q  <= ale_d;
  end

endmodule

// File: tb/tb_exe_mem_issue.sv
// Bench for exe_mem_issue: directed cases with literal expectations plus a
// randomized run checked every cycle against a queue-based reference model.
module tb_exe_mem_issue;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int TW    = 38;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          in_valid, in_allowin, flush, req, req_wr, addr_ok, data_ok;
  logic          out_valid, out_allowin, out_ale;
  logic [3:0]    in_op;
  logic [31:0]   in_addr, req_addr;
  logic [DW-1:0] in_wdata, req_wdata, rdata, out_data;
  logic [TW-1:0] in_tag, out_tag;
  logic [1:0]    req_size;
  logic [3:0]    req_wstrb;

  exe_mem_issue #(.DATA_W(DW), .DEPTH(DEPTH), .TAG_W(TW)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_allowin(in_allowin),
    .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata), .in_tag(in_tag),
    .flush(flush), .req(req), .req_wr(req_wr), .req_size(req_size),
    .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .out_valid(out_valid), .out_allowin(out_allowin), .out_data(out_data),
    .out_tag(out_tag), .out_ale(out_ale));

  // 64-bit instance used for the doubleword case only
  logic          v64, allow64, req64, wr64, aok64, dok64, ov64, oa64, ale64;
  logic [3:0]    op64;
  logic [31:0]   a64, ra64;
  logic [63:0]   wd64, rwd64, rd64, od64;
  logic [TW-1:0] t64, ot64;
  logic [1:0]    rs64;
  logic [7:0]    ws64;

  exe_mem_issue #(.DATA_W(64), .DEPTH(4), .TAG_W(TW)) u_dut64 (
    .clk(clk), .reset(reset), .in_valid(v64), .in_allowin(allow64),
    .in_op(op64), .in_addr(a64), .in_wdata(wd64), .in_tag(t64),
    .flush(1'b0), .req(req64), .req_wr(wr64), .req_size(rs64),
    .req_addr(ra64), .req_wstrb(ws64), .req_wdata(rwd64),
    .addr_ok(aok64), .data_ok(dok64), .rdata(rd64),
    .out_valid(ov64), .out_allowin(oa64), .out_data(od64),
    .out_tag(ot64), .out_ale(ale64));

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [TW-1:0] tag;
    bit            ale;
    bit            st;
    bit            uns;
    int            size;
    int            off;
    bit            done;
    logic [63:0]   data;
  } ent_t;

  ent_t mq[$];
  int   disc     = 0;
  int   bus_pend = 0;

  function automatic bit f_ale(input logic [31:0] a, input int size, input int dw);
    if (size == 3 && dw == 32) return 1'b1;
    return (a % (32'd1 << size)) != 0;
  endfunction

  function automatic logic [63:0] ext_ld(input logic [63:0] raw, input int off,
                                         input int size, input bit uns, input int dw);
    logic [63:0] v, m;
    int nb;
    nb = 1 << size;
    v  = raw >> (8 * off);
    m  = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v  = v & m;
    if (!uns && v[8*nb-1]) v = v | ~m;
    if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  always @(posedge clk) begin : model_upd
    bit   m_ale, m_can, m_allow, m_req, m_pop, hit;
    int   n;
    ent_t e;
    if (reset) begin
      mq.delete();
      disc     = 0;
      bus_pend = 0;
    end else begin
      m_ale   = f_ale(in_addr, int'(in_op[1:0]), DW);
      m_can   = mq.size() < DEPTH;
      m_allow = in_valid && m_can && !flush && (m_ale || addr_ok);
      m_req   = in_valid && !m_ale && m_can && !flush;
      m_pop   = mq.size() > 0 && mq[0].done && out_allowin;
      if (data_ok) begin
        if (bus_pend > 0) bus_pend--;
        if (disc > 0) disc--;
        else begin
          hit = 1'b0;
          for (int i = 0; i < mq.size(); i++) begin
            if (!hit && !mq[i].done) begin
              hit    = 1'b1;
              e      = mq[i];
              e.done = 1'b1;
              e.data = e.st ? 64'd0 : ext_ld({32'd0, rdata}, e.off, e.size, e.uns, DW);
              mq[i]  = e;
            end
          end
        end
      end
      if (m_req && addr_ok) bus_pend++;
      if (flush) begin
        n = 0;
        for (int i = 0; i < mq.size(); i++) if (!mq[i].done) n++;
        disc += n;
        mq.delete();
      end else begin
        if (m_pop) mq.delete(0);
        if (m_allow) begin
          e.tag  = in_tag;
          e.ale  = m_ale;
          e.st   = in_op[3];
          e.uns  = in_op[2];
          e.size = int'(in_op[1:0]);
          e.off  = int'(in_addr[1:0]);
          e.done = m_ale;
          e.data = 64'd0;
          mq.push_back(e);
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin : compare
    bit          c_ale, c_can, c_req, c_allow, c_v;
    int          nb;
    logic [3:0]  ews;
    logic [31:0] ewd;
    #2;
    if (reset) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_req", req, 0);
      chk("rst_in_allowin", in_allowin, 0);
    end else begin
      c_ale   = f_ale(in_addr, int'(in_op[1:0]), DW);
      c_can   = mq.size() < DEPTH;
      c_req   = in_valid && !c_ale && c_can && !flush;
      c_allow = in_valid && c_can && !flush && (c_ale || addr_ok);
      chk("in_allowin", in_allowin, c_allow);
      chk("req", req, c_req);
      if (c_req) begin
        nb  = 1 << int'(in_op[1:0]);
        ews = 4'(((1 << nb) - 1) << int'(in_addr[1:0]));
        for (int i = 0; i < 4; i++) ewd[8*i +: 8] = in_wdata[8*(i % nb) +: 8];
        chk("req_wstrb", req_wstrb, ews);
        chk("req_wdata", req_wdata, ewd);
        chk("req_wr", req_wr, in_op[3]);
        chk("req_size", req_size, in_op[1:0]);
        chk("req_addr", req_addr, in_addr);
      end
      c_v = mq.size() > 0 && mq[0].done;
      chk("out_valid", out_valid, c_v);
      if (c_v) begin
        chk("out_tag", out_tag, mq[0].tag);
        chk("out_ale", out_ale, mq[0].ale);
        if (!mq[0].ale) chk("out_data", out_data, mq[0].data);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    in_valid = 0; flush = 0; addr_ok = 0; data_ok = 0; out_allowin = 0;
    in_op = '0; in_addr = '0; in_wdata = '0; in_tag = '0; rdata = '0;
  endtask

  task automatic op(input logic [3:0] o, input logic [31:0] a,
                    input logic [31:0] wd, input logic [TW-1:0] t);
    in_valid = 1; in_op = o; in_addr = a; in_wdata = wd; in_tag = t;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    idle();
    v64 = 0; op64 = '0; a64 = '0; wd64 = '0; t64 = '0; aok64 = 0; dok64 = 0; rd64 = '0; oa64 = 0;
    in_valid = 1; addr_ok = 1; in_op = 4'b0010; in_addr = 32'h40;
    nxt(); #3;
    chk("reset_req", req, 0);
    chk("reset_allowin", in_allowin, 0);
    chk("reset_out_valid", out_valid, 0);
    nxt(); reset = 0; idle();

    // signed and unsigned byte loads from the top byte lane
    nxt(); idle(); op(4'b0000, 32'h1003, 0, 20); addr_ok = 1; #3;
    chk("ldb_req", req, 1); chk("ldb_wstrb", req_wstrb, 4'b1000);
    nxt(); idle(); data_ok = 1; rdata = 32'h8012_3456;
    nxt(); idle(); out_allowin = 1; #3;
    chk("ldb_valid", out_valid, 1); chk("ldb_signed", out_data, 32'hFFFF_FF80);
    nxt(); idle(); op(4'b0100, 32'h1003, 0, 21); addr_ok = 1;
    nxt(); idle(); data_ok = 1; rdata = 32'h8012_3456;
    nxt(); idle(); out_allowin = 1; #3;
    chk("ldbu_unsigned", out_data, 32'h0000_0080); chk("ldbu_tag", out_tag, 21);

    // halfword store to upper half
    nxt(); idle(); op(4'b1001, 32'h2002, 32'h1234_ABCD, 22); addr_ok = 1; #3;
    chk("sth_wstrb", req_wstrb, 4'b1100); chk("sth_wdata", req_wdata, 32'hABCD_ABCD);
    chk("sth_wr", req_wr, 1);
    nxt(); idle(); data_ok = 1; rdata = 32'hDEAD_BEEF;
    nxt(); idle(); out_allowin = 1; #3;
    chk("sth_valid", out_valid, 1); chk("sth_data", out_data, 0);

    // misaligned word load never reaches the bus
    nxt(); idle(); op(4'b0010, 32'h2001, 0, 23); #3;
    chk("ale_req", req, 0); chk("ale_allow", in_allowin, 1);
    nxt(); idle(); out_allowin = 1; #3;
    chk("ale_valid", out_valid, 1); chk("ale_flag", out_ale, 1);

    // doubleword on a 32-bit bus is illegal
    nxt(); idle(); op(4'b0011, 32'h8, 0, 24); addr_ok = 1; #3;
    chk("ldd32_req", req, 0);
    nxt(); idle(); out_allowin = 1; #3;
    chk("ldd32_ale", out_ale, 1);

    // FIFO full: third load waits until the first pops
    nxt(); idle(); op(4'b0010, 32'h100, 0, 1); addr_ok = 1; #3; chk("full_a", in_allowin, 1);
    nxt(); idle(); op(4'b0010, 32'h104, 0, 2); addr_ok = 1; #3; chk("full_b", in_allowin, 1);
    nxt(); idle(); op(4'b0010, 32'h108, 0, 3); addr_ok = 1; #3; chk("full_c_blk", in_allowin, 0);
    nxt(); data_ok = 1; rdata = 32'hAAAA_0001; #3; chk("full_c_blk2", in_allowin, 0);
    nxt(); data_ok = 0; out_allowin = 1; #3;
    chk("full_pop_blk", in_allowin, 0); chk("full_tag1", out_tag, 1);
    chk("full_data1", out_data, 32'hAAAA_0001);
    nxt(); out_allowin = 0; #3; chk("full_c_ok", in_allowin, 1);
    nxt(); idle(); data_ok = 1; rdata = 32'hBBBB_0002;
    nxt(); idle(); data_ok = 1; rdata = 32'hCCCC_0003; out_allowin = 1; #3;
    chk("full_tag2", out_tag, 2); chk("full_data2", out_data, 32'hBBBB_0002);
    nxt(); idle(); out_allowin = 1; #3;
    chk("full_tag3", out_tag, 3); chk("full_data3", out_data, 32'hCCCC_0003);
    nxt(); idle(); #3; chk("full_empty", out_valid, 0);

    // flush with two loads outstanding, then a fresh load
    nxt(); idle(); op(4'b0010, 32'h200, 0, 10); addr_ok = 1;
    nxt(); idle(); op(4'b0010, 32'h204, 0, 11); addr_ok = 1;
    nxt(); idle(); flush = 1;
    nxt(); idle(); op(4'b0010, 32'h208, 0, 12); addr_ok = 1; #3; chk("fl_new_allow", in_allowin, 1);
    nxt(); idle(); data_ok = 1; rdata = 32'h1111_1111;
    nxt(); idle(); data_ok = 1; rdata = 32'h2222_2222; #3; chk("fl_drop1", out_valid, 0);
    nxt(); idle(); data_ok = 1; rdata = 32'h3333_3333; #3; chk("fl_drop2", out_valid, 0);
    nxt(); idle(); out_allowin = 1; #3;
    chk("fl_valid", out_valid, 1); chk("fl_tag", out_tag, 12); chk("fl_data", out_data, 32'h3333_3333);

    // doubleword load on the 64-bit instance
    nxt(); idle(); v64 = 1; op64 = 4'b0011; a64 = 32'h8; t64 = 50; aok64 = 1; #3;
    chk("ldd64_req", req64, 1); chk("ldd64_size", rs64, 3); chk("ldd64_wstrb", ws64, 8'hFF);
    nxt(); v64 = 0; aok64 = 0; dok64 = 1; rd64 = 64'h8765_4321_1234_5678;
    nxt(); dok64 = 0; oa64 = 1; #3;
    chk("ldd64_valid", ov64, 1); chk("ldd64_data", od64, 64'h8765_4321_1234_5678);
    nxt(); oa64 = 0;

    // reset in the middle of an outstanding load; later response is ignored
    nxt(); idle(); op(4'b0010, 32'h300, 0, 40); addr_ok = 1;
    nxt(); idle(); reset = 1; op(4'b0010, 32'h304, 0, 41); addr_ok = 1;
    nxt();
    nxt(); reset = 0; idle(); data_ok = 1; rdata = 32'h5555_5555;
    nxt(); idle(); #3; chk("rst_mid_valid", out_valid, 0);
    nxt(); idle(); #3; chk("rst_mid_valid2", out_valid, 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int sz;
      nxt();
      sz          = int'($urandom % 4);
      in_valid    = ($urandom % 10) < 7;
      in_op       = {1'($urandom % 2), 1'($urandom % 2), 2'(sz)};
      in_addr     = $urandom;
      if ($urandom % 2) in_addr[2:0] = 3'b000;
      in_wdata    = $urandom;
      in_tag      = TW'({$urandom, $urandom});
      addr_ok     = ($urandom % 10) < 6;
      flush       = ($urandom % 25) == 0;
      out_allowin = ($urandom % 10) < 7;
      data_ok     = (bus_pend > 0) && (($urandom % 2) == 1);
      rdata       = $urandom;
    end

    nxt(); idle();
    repeat (4) nxt();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
